game_move_controller: RTL and testbench
=======================================

GAME_MOVE_CONTROLLER -- requirements
Module: game_move_controller

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, initial nonzero seed of the spawn LFSR.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 15, maximum cycles to wait for mm_done.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port move_req  in  1  a move request from the player; held until move_ack.
REQ-006 SHALL have port move_dir  in  4  one-hot move direction: 0001 up, 0010 down, 0100 left, 1000 right.
REQ-007 SHALL have port move_ack  out  1  one-cycle pulse: request accepted or rejected.
REQ-008 SHALL have port mm_direction  out  4  direction to the merge block; 0000 when idle.
REQ-009 SHALL have port mm_board_in  out  12x4x4  registered board to the merge block.
REQ-010 SHALL have port mm_board_out  in  12x4x4  merged board from the merge block.
REQ-011 SHALL have port mm_score_update  in  20  points from the merge.
REQ-012 SHALL have port mm_done  in  1  merge result valid.
REQ-013 SHALL have port board  out  12x4x4  current board; tile value stored literally (2, 4, ... 0x800), 0 = empty.
REQ-014 SHALL have port score  out  20  accumulated score.
REQ-015 SHALL have ports busy, game_won, game_over  out  1 each  status flags.

Function
REQ-016 SHALL implement the FSM states INIT, IDLE, ISSUE, WAIT, SPAWN, CHECK.
REQ-017 INIT SHALL spawn one tile per cycle for 2 cycles, then go to IDLE.
REQ-018 In IDLE, move_req with a valid one-hot move_dir and game_over=0 SHALL pulse move_ack and go to ISSUE.
REQ-019 In IDLE, move_req with a non-one-hot move_dir or with game_over=1 SHALL pulse move_ack and stay in IDLE with no state change.
REQ-020 ISSUE SHALL drive mm_direction=move_dir for exactly 1 cycle, then go to WAIT while holding mm_direction.
REQ-021 In WAIT, mm_done=1 SHALL capture mm_board_out, set score += mm_score_update, drop mm_direction to 0000, and go to SPAWN.
REQ-022 If mm_board_out equals the prior board, SPAWN SHALL be skipped (direct to CHECK).
REQ-023 Score addition SHALL saturate at 20'hFFFFF.
REQ-024 If mm_done does not arrive within DONE_TIMEOUT cycles of entering WAIT, the controller SHALL discard the move (board and score unchanged) and return to IDLE.
REQ-025 SPAWN SHALL scan the cells from index lfsr[3:0] (row*4+col), wrapping at 15, and place a tile in the first empty cell.
REQ-026 The spawned tile SHALL be 4 if lfsr[7:4]==0, else 2.
REQ-027 The LFSR SHALL be a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle.
REQ-028 If no cell is empty, SPAWN SHALL place nothing.
REQ-029 CHECK SHALL set game_won if any cell equals 0x800; game_won is sticky until reset.
REQ-030 CHECK SHALL set game_over if there are no empty cells and no horizontally or vertically adjacent equal pair; then go to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 move_req SHALL be ignored (no ack) while busy.

Reset
REQ-033 rst_n=0 at a clock edge SHALL clear board, score, mm_board_in, mm_direction, move_ack, game_won and game_over to 0, load LFSR_SEED, and enter INIT.
REQ-034 Reset during WAIT SHALL abandon the in-flight move; a later mm_done SHALL be ignored outside WAIT.

Structure
REQ-035 A shared package game2048_pkg SHALL hold the tile width (12), the score width (20), the direction encodings, the WIN_TILE=12'h800 constant and the board typedef.
REQ-036 The sub-module tile_spawner (LFSR, empty-cell scan, tile pick) SHALL be instantiated once.

Verification
REQ-037 Bench SHALL cover: reset, then idle -> exactly 2 nonzero cells each 2 or 4, score=0, busy=0 after INIT.
REQ-038 Bench SHALL cover: board row0=2,2,4,4 with merge model returning 4,8,0,0 and score 12, move left 0100 -> score=12, one new tile, move_ack pulsed once.
REQ-039 Bench SHALL cover: merge model returning an unchanged board -> no spawn, board identical, score += 0.
REQ-040 Bench SHALL cover: mm_done withheld 16 cycles -> return to IDLE, board and score unchanged, mm_direction=0000.
REQ-041 Bench SHALL cover: merged board containing 0x800 -> game_won=1 and it stays 1 after further moves.
REQ-042 Bench SHALL cover: full checkerboard 2/4 with no pairs -> game_over=1, and a subsequent move_req is acked with no ISSUE.

Source files
------------

// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 move controller: tile/score widths,
// move directions, board layout and FSM state encoding.
package game2048_pkg;

    localparam int TILE_W  = 12;
    localparam int SCORE_W = 20;
    localparam int CELLS   = 16;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam logic [TILE_W-1:0] WIN_TILE = 12'h800;
    localparam logic [TILE_W-1:0] TILE_2   = 12'd2;
    localparam logic [TILE_W-1:0] TILE_4   = 12'd4;

    // board[row][col]; flattened cell index is row*4+col
    typedef logic [3:0][3:0][TILE_W-1:0] board_t;
    typedef logic [CELLS-1:0][TILE_W-1:0] cells_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SPAWN,
        ST_CHECK
    } state_t;

    function automatic logic dir_valid(input logic [3:0] dir);
        return (dir == DIR_UP) || (dir == DIR_DOWN) ||
               (dir == DIR_LEFT) || (dir == DIR_RIGHT);
    endfunction

    function automatic logic [SCORE_W-1:0] score_add_sat(input logic [SCORE_W-1:0] a,
                                                         input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/tile_spawner.sv
// Free-running 16-bit LFSR plus first-empty-cell scan; presents the board with
// one new 2/4 tile placed (or unchanged when the board is full).
module tile_spawner
    import game2048_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  board_t board_cur,
    output board_t board_spawned
);

    logic [15:0]       lfsr;
    logic              feedback;
    cells_t            cells_in;
    cells_t            cells_out;
    logic              found;
    logic [3:0]        pos;
    logic [3:0]        idx;
    logic [TILE_W-1:0] tile;

    // Fibonacci taps 16,14,13,11
    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

    assign cells_in = cells_t'(board_cur);
    assign tile     = (lfsr[7:4] == 4'd0) ? TILE_4 : TILE_2;

    // Start at lfsr[3:0]; the 4-bit add wraps past cell 15 back to cell 0
    always_comb begin
        found = 1'b0;
        pos   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            idx = lfsr[3:0] + 4'(k);
            if (!found && (cells_in[idx] == '0)) begin
                found = 1'b1;
                pos   = idx;
            end
        end
    end

    always_comb begin
        cells_out = cells_in;
        if (found) begin
            cells_out[pos] = tile;
        end
    end

    assign board_spawned = board_t'(cells_out);

endmodule

// File: rtl/game_move_controller.sv
// 2048 move sequencer: accepts player moves, hands the board to the external
// merge block, folds in the result, spawns a tile and updates win/lose status.
module game_move_controller
    import game2048_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned DONE_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               move_req,
    input  logic [3:0]         move_dir,
    output logic               move_ack,
    output logic [3:0]         mm_direction,
    output board_t             mm_board_in,
    input  board_t             mm_board_out,
    input  logic [SCORE_W-1:0] mm_score_update,
    input  logic               mm_done,
    output board_t             board,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               game_won,
    output logic               game_over
);

    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DONE_TIMEOUT - 1);

    state_t             state;
    state_t             state_next;
    board_t             board_q;
    board_t             board_mm_q;
    board_t             spawn_board;
    logic [SCORE_W-1:0] score_q;
    logic [3:0]         dir_q;
    logic               ack_q;
    logic               won_q;
    logic               over_q;
    logic               init_cnt;
    logic [CNT_W-1:0]   wait_cnt;

    logic ack_set;
    logic start_move;
    logic capture;
    logic abort;
    logic spawn_load;
    logic check_en;
    logic any_win;
    logic any_empty;
    logic any_pair;

    tile_spawner #(
        .LFSR_SEED(LFSR_SEED)
    ) u_spawner (
        .clk          (clk),
        .rst_n        (rst_n),
        .board_cur    (board_q),
        .board_spawned(spawn_board)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ack_set    = 1'b0;
        start_move = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        spawn_load = 1'b0;
        check_en   = 1'b0;
        case (state)
            ST_INIT: begin
                spawn_load = 1'b1;
                if (init_cnt) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // ack_q guard stops a request still held on the ack cycle from being taken twice
                if (move_req && !ack_q) begin
                    ack_set = 1'b1;
                    if (dir_valid(move_dir) && !over_q) begin
                        start_move = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mm_done) begin
                    capture    = 1'b1;
                    state_next = (mm_board_out == board_q) ? ST_CHECK : ST_SPAWN;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_SPAWN: begin
                spawn_load = 1'b1;
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                check_en   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_comb begin
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (board_q[2'(r)][2'(c)] == WIN_TILE) begin
                    any_win = 1'b1;
                end
                if (board_q[2'(r)][2'(c)] == '0) begin
                    any_empty = 1'b1;
                end
                if ((c < 3) && (board_q[2'(r)][2'(c)] == board_q[2'(r)][2'(c + 1)])) begin
                    any_pair = 1'b1;
                end
                if ((r < 3) && (board_q[2'(r)][2'(c)] == board_q[2'(r + 1)][2'(c)])) begin
                    any_pair = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            board_q    <= '0;
            board_mm_q <= '0;
            score_q    <= '0;
            dir_q      <= DIR_NONE;
            ack_q      <= 1'b0;
            won_q      <= 1'b0;
            over_q     <= 1'b0;
            init_cnt   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            ack_q    <= ack_set;
            init_cnt <= (state == ST_INIT);
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            if (start_move) begin
                dir_q      <= move_dir;
                board_mm_q <= board_q;
            end
            if (capture || abort) begin
                dir_q <= DIR_NONE;
            end
            if (capture) begin
                board_q <= mm_board_out;
                score_q <= score_add_sat(score_q, mm_score_update);
            end
            if (spawn_load) begin
                board_q <= spawn_board;
            end
            if (check_en) begin
                won_q  <= won_q | any_win;
                over_q <= !any_empty && !any_pair;
            end
        end
    end

    assign move_ack     = ack_q;
    assign mm_direction = dir_q;
    assign mm_board_in  = board_mm_q;
    assign board        = board_q;
    assign score        = score_q;
    assign busy         = (state != ST_IDLE);
    assign game_won     = won_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_game_move_controller.sv
// Scoreboard bench for game_move_controller: stimulus queues expected move
// outcomes, a merge-block model answers the DUT, a monitor checks each ack.
module tb_game_move_controller;
    import game2048_pkg::*;

    localparam int M_EXACT = 0;
    localparam int M_SPAWN = 1;
    localparam int M_UNCH  = 2;

    typedef struct {
        string       name;
        logic [3:0]  dir;
        bit          accept;
        bit          withhold;
        bit          identity;
        bit          check_in;
        board_t      exp_in;
        board_t      merge_out;
        logic [19:0] merge_score;
        int          mode;
        logic [19:0] exp_score;
        bit          exp_won;
        bit          exp_over;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        move_req;
    logic [3:0]  move_dir;
    logic        move_ack;
    logic [3:0]  mm_direction;
    board_t      mm_board_in;
    board_t      mm_board_out;
    logic [19:0] mm_score_update;
    logic        mm_done;
    board_t      board;
    logic [19:0] score;
    logic        busy;
    logic        game_won;
    logic        game_over;

    int     checks = 0;
    int     errors = 0;
    int     mon_done = 0;
    txn_t   exp_q[$];
    txn_t   merge_q[$];
    board_t last_merge_out = '0;
    board_t model_board = '0;

    always #5 clk = ~clk;

    game_move_controller #(
        .LFSR_SEED   (16'hACE1),
        .DONE_TIMEOUT(15)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .move_req       (move_req),
        .move_dir       (move_dir),
        .move_ack       (move_ack),
        .mm_direction   (mm_direction),
        .mm_board_in    (mm_board_in),
        .mm_board_out   (mm_board_out),
        .mm_score_update(mm_score_update),
        .mm_done        (mm_done),
        .board          (board),
        .score          (score),
        .busy           (busy),
        .game_won       (game_won),
        .game_over      (game_over)
    );

    task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input board_t act, input board_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic board_t mkb(input logic [47:0] r0, input logic [47:0] r1,
                                   input logic [47:0] r2, input logic [47:0] r3);
        board_t b;
        for (int c = 0; c < 4; c++) begin
            b[0][2'(c)] = r0[47-12*c -: 12];
            b[1][2'(c)] = r1[47-12*c -: 12];
            b[2][2'(c)] = r2[47-12*c -: 12];
            b[3][2'(c)] = r3[47-12*c -: 12];
        end
        return b;
    endfunction

    function automatic txn_t mk(input string name, input logic [3:0] dir, input bit accept,
                                input int mode, input board_t mout, input bit identity,
                                input logic [19:0] mscore, input logic [19:0] escore,
                                input bit won, input bit over);
        txn_t t;
        t.name = name;          t.dir = dir;           t.accept = accept;
        t.withhold = accept && (mode == M_UNCH);
        t.identity = identity;  t.check_in = 1'b0;     t.exp_in = '0;
        t.merge_out = mout;     t.merge_score = mscore; t.mode = mode;
        t.exp_score = escore;   t.exp_won = won;       t.exp_over = over;
        return t;
    endfunction

    // Exactly one cell differs from base: it was empty there and now holds 2 or 4
    function automatic bit one_spawn(input board_t act, input board_t base);
        int diff = 0;
        bit ok = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (act[2'(r)][2'(c)] != base[2'(r)][2'(c)]) begin
                    diff++;
                    if (base[2'(r)][2'(c)] != '0 ||
                        !(act[2'(r)][2'(c)] == 12'd2 || act[2'(r)][2'(c)] == 12'd4)) ok = 1'b0;
                end
            end
        end
        return ok && (diff == 1);
    endfunction

    // Merge block model: answers each issued direction from merge_q
    initial begin
        txn_t   m;
        board_t out;
        mm_done = 1'b0;
        mm_board_out = '0;
        mm_score_update = '0;
        forever begin
            @(negedge clk);
            if (mm_direction != DIR_NONE) begin
                if (merge_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL merge_unexpected: direction %b issued with no move queued", mm_direction);
                end else begin
                    m = merge_q.pop_front();
                    chk_v({m.name, "_mm_direction"}, 32'(mm_direction), 32'(m.dir));
                    if (m.check_in) chk_b({m.name, "_mm_board_in"}, mm_board_in, m.exp_in);
                    out = m.identity ? mm_board_in : m.merge_out;
                    last_merge_out = out;
                    if (!m.withhold) begin
                        @(negedge clk);
                        @(negedge clk);
                        mm_board_out = out;
                        mm_score_update = m.merge_score;
                        mm_done = 1'b1;
                        @(negedge clk);
                        mm_done = 1'b0;
                        mm_score_update = '0;
                    end
                end
                for (int i = 0; i < 40 && mm_direction != DIR_NONE; i++) @(negedge clk);
            end
        end
    end

    // Monitor: every ack pops one expectation and checks the settled outcome
    initial begin
        txn_t   t;
        board_t exp_b;
        int     extra;
        int     n;
        bit     issued;
        forever begin
            @(negedge clk);
            if (move_ack) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: move_ack with no request outstanding");
                end else begin
                    t = exp_q.pop_front();
                    if (t.accept) begin
                        extra = 0;
                        n = 0;
                        while (busy && n < 80) begin
                            @(negedge clk);
                            if (move_ack) extra++;
                            n++;
                        end
                        chk_v({t.name, "_busy_done"}, 32'(busy), 32'd0);
                        chk_v({t.name, "_ack_once"}, 32'(extra), 32'd0);
                    end else begin
                        issued = busy || (mm_direction != DIR_NONE);
                        for (int i = 0; i < 3; i++) begin
                            @(negedge clk);
                            if (busy || mm_direction != DIR_NONE) issued = 1'b1;
                        end
                        chk_v({t.name, "_no_issue"}, 32'(issued), 32'd0);
                    end
                    chk_v({t.name, "_score"}, 32'(score), 32'(t.exp_score));
                    chk_v({t.name, "_game_won"}, 32'(game_won), 32'(t.exp_won));
                    chk_v({t.name, "_game_over"}, 32'(game_over), 32'(t.exp_over));
                    chk_v({t.name, "_mm_dir_idle"}, 32'(mm_direction), 32'd0);
                    if (t.mode == M_EXACT) begin
                        exp_b = t.identity ? last_merge_out : t.merge_out;
                        chk_b({t.name, "_board"}, board, exp_b);
                        model_board = exp_b;
                    end else if (t.mode == M_SPAWN) begin
                        chk_v({t.name, "_one_spawn"}, 32'(one_spawn(board, t.merge_out)), 32'd1);
                    end else begin
                        chk_b({t.name, "_board_unchanged"}, board, model_board);
                    end
                end
                mon_done++;
            end
        end
    end

    task automatic wait_init(input string name);
        int n = 0;
        int tiles = 0;
        bit vals_ok = 1'b1;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_v({name, "_busy"}, 32'(busy), 32'd0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board[2'(r)][2'(c)] != '0) begin
                    tiles++;
                    if (board[2'(r)][2'(c)] != 12'd2 && board[2'(r)][2'(c)] != 12'd4) vals_ok = 1'b0;
                end
            end
        end
        chk_v({name, "_tile_count"}, 32'(tiles), 32'd2);
        chk_v({name, "_tile_values"}, 32'(vals_ok), 32'd1);
        chk_v({name, "_score"}, 32'(score), 32'd0);
        chk_v({name, "_game_won"}, 32'(game_won), 32'd0);
        chk_v({name, "_game_over"}, 32'(game_over), 32'd0);
        chk_v({name, "_mm_direction"}, 32'(mm_direction), 32'd0);
    endtask

    task automatic do_move(input txn_t t);
        int target;
        bit got = 1'b0;
        target = mon_done + 1;
        exp_q.push_back(t);
        if (t.accept) merge_q.push_back(t);
        move_dir = t.dir;
        move_req = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (move_ack) got = 1'b1;
        end
        move_req = 1'b0;
        move_dir = DIR_NONE;
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_ack: got no move_ack expected one within 10 cycles", t.name);
            exp_q.delete();
            merge_q.delete();
        end else begin
            for (int i = 0; i < 100 && mon_done < target; i++) @(negedge clk);
            if (mon_done < target) begin
                checks++; errors++;
                $display("FAIL %s_complete: got no result expected one within 100 cycles", t.name);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        board_t f1, m2, w1, cb;
        txn_t   t;
        f1 = mkb(48'h002_002_004_004, 48'h008_010_020_040, 48'h080_100_200_400, 48'h002_008_002_008);
        m2 = mkb(48'h004_008_000_000, 48'h008_010_020_040, 48'h080_100_200_400, 48'h002_008_002_008);
        w1 = mkb(48'h800_000_000_000, 48'h002_000_000_000, 48'h0, 48'h0);
        cb = mkb(48'h002_004_002_004, 48'h004_002_004_002, 48'h002_004_002_004, 48'h004_002_004_002);

        rst_n = 1'b0;
        move_req = 1'b0;
        move_dir = DIR_NONE;
        repeat (2) @(negedge clk);
        chk_b("reset_board", board, '0);
        chk_b("reset_mm_board_in", mm_board_in, '0);
        chk_v("reset_score", 32'(score), 32'd0);
        chk_v("reset_move_ack", 32'(move_ack), 32'd0);
        chk_v("reset_mm_direction", 32'(mm_direction), 32'd0);
        chk_v("reset_flags", 32'({game_won, game_over}), 32'd0);
        rst_n = 1'b1;
        wait_init("init");

        // Full board with pairs: spawn finds no empty cell, no game over
        do_move(mk("setup_full", DIR_UP, 1'b1, M_EXACT, f1, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0));
        t = mk("left_merge", DIR_LEFT, 1'b1, M_SPAWN, m2, 1'b0, 20'd12, 20'd12, 1'b0, 1'b0);
        t.check_in = 1'b1;
        t.exp_in = f1;
        do_move(t);
        do_move(mk("unchanged", DIR_RIGHT, 1'b1, M_EXACT, '0, 1'b1, 20'd0, 20'd12, 1'b0, 1'b0));
        do_move(mk("bad_dir_0011", 4'b0011, 1'b0, M_UNCH, '0, 1'b0, 20'd0, 20'd12, 1'b0, 1'b0));
        do_move(mk("bad_dir_0000", 4'b0000, 1'b0, M_UNCH, '0, 1'b0, 20'd0, 20'd12, 1'b0, 1'b0));
        do_move(mk("timeout", DIR_DOWN, 1'b1, M_UNCH, '0, 1'b0, 20'd0, 20'd12, 1'b0, 1'b0));
        do_move(mk("win", DIR_UP, 1'b1, M_SPAWN, w1, 1'b0, 20'd2048, 20'd2060, 1'b1, 1'b0));
        do_move(mk("won_sticky", DIR_DOWN, 1'b1, M_EXACT, '0, 1'b1, 20'd0, 20'd2060, 1'b1, 1'b0));
        do_move(mk("checker_sat", DIR_LEFT, 1'b1, M_EXACT, cb, 1'b0, 20'hFFFFF, 20'hFFFFF, 1'b1, 1'b1));
        do_move(mk("after_over", DIR_UP, 1'b0, M_UNCH, '0, 1'b0, 20'd0, 20'hFFFFF, 1'b1, 1'b1));

        rst_n = 1'b0;
        @(negedge clk);
        chk_v("rereset_flags", 32'({game_won, game_over}), 32'd0);
        chk_v("rereset_score", 32'(score), 32'd0);
        rst_n = 1'b1;
        wait_init("reinit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
